// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: lets N requesters share one ALU datapath.
// Round-robin grant, fixed-latency execution, and a response that is held
// on a shared bus until the granted requester accepts it.
module alu_req_scheduler #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int CW      = 16,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*OPW-1:0]     req_opcode,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic [N-1:0]         rsp_valid,
    input  logic [N-1:0]         rsp_ready,
    output logic [CW-1:0]        rsp_c,
    output logic                 rsp_dbz,
    output logic [OPW-1:0]       alu_opcode,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    input  logic [CW-1:0]        alu_c,
    input  logic                 alu_dbz,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int IDW  = $clog2(N);
    localparam int CNTW = 4;  // holds latencies up to 15
    localparam logic [IDW-1:0] PTR_RST = IDW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;      // last requester served
    logic [IDW-1:0]  grant_q, grant_d;  // current owner
    logic [CNTW-1:0] cnt_q, cnt_d;      // remaining EXEC cycles
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic [CW-1:0]   rsp_c_q, rsp_c_d;
    logic            rsp_dbz_q, rsp_dbz_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  scan_idx;

    // Round-robin pick: first valid requester after the last one served.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path leaves it holding state (no latch).
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            scan_idx = IDW'((int'(ptr_q) + k) % N);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // Next-state logic: grant, count down the ALU latency, hold the response.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        alu_op_d  = alu_op_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        rsp_c_d   = rsp_c_q;
        rsp_dbz_d = rsp_dbz_q;

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    alu_op_d = req_opcode[gnt_idx*OPW +: OPW];
                    alu_a_d  = req_a[gnt_idx*W +: W];
                    alu_b_d  = req_b[gnt_idx*W +: W];
                    grant_d  = gnt_idx;
                    cnt_d    = CNTW'(ALU_LAT);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // The last EXEC cycle is the one where the ALU output is valid.
                if (cnt_q <= CNTW'(1)) begin
                    rsp_c_d   = alu_c;
                    rsp_dbz_d = alu_dbz;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            RESP: begin
                // Only the owner's accept matters; the owner then drops to
                // lowest priority for the next round.
                if (rsp_ready[grant_q]) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs: grant only in IDLE, response only in RESP.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        // Held at zero while reset is asserted so every output reads 0.
        if (state_q == IDLE && gnt_found && !reset) begin
            req_ready = N'(1) << gnt_idx;
        end
        if (state_q == RESP) begin
            rsp_valid = N'(1) << grant_q;
        end
    end

    // State registers; reset puts priority back on requester 0.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_RST;
            grant_q   <= '0;
            cnt_q     <= '0;
            alu_op_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            rsp_c_q   <= '0;
            rsp_dbz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            rsp_c_q   <= rsp_c_d;
            rsp_dbz_q <= rsp_dbz_d;
        end
    end

    assign alu_opcode = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_dbz    = rsp_dbz_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;

endmodule
